// File: rtl/cs_address_sequencer.sv
// Control-store address sequencer for the ARC microcode store: holds CSAR and the PSR flags,
// and picks the next microaddress (increment, conditional/unconditional jump or opcode DECODE).
module cs_address_sequencer #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32,
    parameter int DATAWIDTH_COUNT       = 16
) (
    input  logic                             MICROCODE_STORE_CLOCK_50,
    input  logic                             MICROCODE_STORE_ResetInHigh_In,
    input  logic                             SEQ_Enable_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   SEQ_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] SEQ_JumpAddress_InBus,
    input  logic [DATAWIDTH_IR-1:0]          SEQ_IR_InBus,
    input  logic                             SEQ_FlagN_In,
    input  logic                             SEQ_FlagZ_In,
    input  logic                             SEQ_FlagV_In,
    input  logic                             SEQ_FlagC_In,
    input  logic                             SEQ_FlagsLoad_In,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] SEQ_CSAddress_OutBus,
    output logic                             SEQ_MicroValid_Out,
    output logic [3:0]                       SEQ_PSR_OutBus,
    output logic [DATAWIDTH_COUNT-1:0]       SEQ_MicroCount_OutBus
);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam logic [DATAWIDTH_CONDITION-1:0] COND_NEXT   = DATAWIDTH_CONDITION'(0);
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_N      = DATAWIDTH_CONDITION'(1);
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_Z      = DATAWIDTH_CONDITION'(2);
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_V      = DATAWIDTH_CONDITION'(3);
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_C      = DATAWIDTH_CONDITION'(4);
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_IR13   = DATAWIDTH_CONDITION'(5);
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_JUMP   = DATAWIDTH_CONDITION'(6);
    localparam logic [DATAWIDTH_CONDITION-1:0] COND_DECODE = DATAWIDTH_CONDITION'(7);

    state_t                             state_q, state_d;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   csar_q, csar_d;
    logic                               valid_q, valid_d;
    logic [3:0]                         psr_q, psr_d;
    logic [DATAWIDTH_COUNT-1:0]         count_q, count_d;

    logic [DATAWIDTH_JUMPADDRESS-1:0]   csar_inc;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   decode_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0]   next_addr;
    logic                               take_jump;

    // psr_q bit order is {n, z, v, c}
    logic flag_n, flag_z, flag_v, flag_c;
    assign flag_n = psr_q[3];
    assign flag_z = psr_q[2];
    assign flag_v = psr_q[1];
    assign flag_c = psr_q[0];

    assign csar_inc    = csar_q + DATAWIDTH_JUMPADDRESS'(1);
    assign decode_addr = DATAWIDTH_JUMPADDRESS'({1'b1, SEQ_IR_InBus[31:30], SEQ_IR_InBus[24:19], 2'b00});

    logic unused_ir_bits;
    assign unused_ir_bits = &{1'b0, SEQ_IR_InBus[29:25], SEQ_IR_InBus[18:14], SEQ_IR_InBus[12:0]};

    // Conditions test the PSR as it stood before this microword's own flag load.
    always_comb begin
        take_jump = 1'b0;
        unique case (SEQ_Condition_InBus)
            COND_NEXT:   take_jump = 1'b0;
            COND_N:      take_jump = flag_n;
            COND_Z:      take_jump = flag_z;
            COND_V:      take_jump = flag_v;
            COND_C:      take_jump = flag_c;
            COND_IR13:   take_jump = SEQ_IR_InBus[13];
            COND_JUMP:   take_jump = 1'b1;
            COND_DECODE: take_jump = 1'b0;
            default:     take_jump = 1'b0;
        endcase
    end

    always_comb begin
        if (SEQ_Condition_InBus == COND_DECODE) begin
            next_addr = decode_addr;
        end else if (take_jump) begin
            next_addr = SEQ_JumpAddress_InBus;
        end else begin
            next_addr = csar_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        csar_d  = csar_q;
        valid_d = valid_q;
        psr_d   = psr_q;
        count_d = count_q;
        if (SEQ_Enable_In) begin
            unique case (state_q)
                ST_WAIT: begin
                    state_d = ST_EXEC;
                    valid_d = 1'b1;
                end
                ST_EXEC: begin
                    state_d = ST_WAIT;
                    valid_d = 1'b0;
                    csar_d  = next_addr;
                    count_d = count_q + DATAWIDTH_COUNT'(1);
                    if (SEQ_FlagsLoad_In) begin
                        psr_d = {SEQ_FlagN_In, SEQ_FlagZ_In, SEQ_FlagV_In, SEQ_FlagC_In};
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge MICROCODE_STORE_CLOCK_50 or posedge MICROCODE_STORE_ResetInHigh_In) begin
        if (MICROCODE_STORE_ResetInHigh_In) begin
            state_q <= ST_WAIT;
            csar_q  <= '0;
            valid_q <= 1'b0;
            psr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            csar_q  <= csar_d;
            valid_q <= valid_d;
            psr_q   <= psr_d;
            count_q <= count_d;
        end
    end

    assign SEQ_CSAddress_OutBus  = csar_q;
    assign SEQ_MicroValid_Out    = valid_q;
    assign SEQ_PSR_OutBus        = psr_q;
    assign SEQ_MicroCount_OutBus = count_q;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed bench for cs_address_sequencer: walks microinstructions through WAIT/EXEC and checks
// CSAR, PSR, valid and count against hand-computed values.
module tb_cs_address_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [2:0]  cond;
    logic [10:0] jump_addr;
    logic [31:0] ir;
    logic        flag_n, flag_z, flag_v, flag_c;
    logic        flags_load;
    logic [10:0] cs_address;
    logic        micro_valid;
    logic [3:0]  psr;
    logic [15:0] micro_count;

    int check_count = 0;
    int error_count = 0;

    cs_address_sequencer dut (
        .MICROCODE_STORE_CLOCK_50       (clk),
        .MICROCODE_STORE_ResetInHigh_In (rst),
        .SEQ_Enable_In                  (enable),
        .SEQ_Condition_InBus            (cond),
        .SEQ_JumpAddress_InBus          (jump_addr),
        .SEQ_IR_InBus                   (ir),
        .SEQ_FlagN_In                   (flag_n),
        .SEQ_FlagZ_In                   (flag_z),
        .SEQ_FlagV_In                   (flag_v),
        .SEQ_FlagC_In                   (flag_c),
        .SEQ_FlagsLoad_In               (flags_load),
        .SEQ_CSAddress_OutBus           (cs_address),
        .SEQ_MicroValid_Out             (micro_valid),
        .SEQ_PSR_OutBus                 (psr),
        .SEQ_MicroCount_OutBus          (micro_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    // Entered and left at a negedge with the FSM in WAIT; flags are {n,z,v,c}.
    task automatic step_micro(input string tag, input logic [2:0] c, input logic [10:0] j,
                              input logic [31:0] ir_v, input logic [3:0] flags, input logic ld,
                              input logic [10:0] exp_csar, input logic [3:0] exp_psr);
        cond       = c;
        jump_addr  = j;
        ir         = ir_v;
        {flag_n, flag_z, flag_v, flag_c} = flags;
        flags_load = ld;
        check_value({tag, " wait_valid"}, 32'(micro_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_value({tag, " exec_valid"}, 32'(micro_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_value({tag, " csar"}, 32'(cs_address), 32'(exp_csar));
        check_value({tag, " psr"}, 32'(psr), 32'(exp_psr));
        flags_load = 1'b0;
        $display("micro %-10s cond=%0d jump=%0d ir=%h -> csar=%0d psr=%b count=%0d",
                 tag, c, j, ir_v, cs_address, psr, micro_count);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        cond       = 3'd0;
        jump_addr  = 11'd0;
        ir         = 32'd0;
        {flag_n, flag_z, flag_v, flag_c} = 4'b0000;
        flags_load = 1'b0;

        repeat (3) @(negedge clk);
        check_value("reset csar", 32'(cs_address), 32'd0);
        check_value("reset valid", 32'(micro_valid), 32'd0);
        check_value("reset psr", 32'(psr), 32'd0);
        check_value("reset count", 32'(micro_count), 32'd0);
        rst = 1'b0;

        // Sequential increments
        step_micro("inc0", 3'b000, 11'd0, 32'd0, 4'b0000, 1'b0, 11'd1, 4'b0000);
        step_micro("inc1", 3'b000, 11'd0, 32'd0, 4'b0000, 1'b0, 11'd2, 4'b0000);
        step_micro("inc2", 3'b000, 11'd0, 32'd0, 4'b0000, 1'b0, 11'd3, 4'b0000);
        step_micro("inc3", 3'b000, 11'd0, 32'd0, 4'b0000, 1'b0, 11'd4, 4'b0000);
        check_value("count after 4", 32'(micro_count), 32'd4);

        // DECODE
        step_micro("dec_op10", 3'b111, 11'd0, 32'h8080_0000, 4'b0000, 1'b0, 11'd1600, 4'b0000);
        step_micro("dec_op00", 3'b111, 11'd0, 32'h0080_0000, 4'b0000, 1'b0, 11'd1088, 4'b0000);

        // Z branch after a flag load in the previous microword
        step_micro("setz", 3'b000, 11'd0, 32'd0, 4'b0100, 1'b1, 11'd1089, 4'b0100);
        step_micro("brz_old", 3'b010, 11'd1604, 32'd0, 4'b0000, 1'b0, 11'd1604, 4'b0100);

        // Z branch in the same microword that sets z uses the old z
        step_micro("clrz", 3'b000, 11'd0, 32'd0, 4'b0000, 1'b1, 11'd1605, 4'b0000);
        step_micro("brz_same", 3'b010, 11'd1604, 32'd0, 4'b0100, 1'b1, 11'd1606, 4'b0100);
        check_value("count after z", 32'(micro_count), 32'd10);

        // N, V, C, Z conditions with psr = n,c set
        step_micro("setnc", 3'b000, 11'd0, 32'd0, 4'b1001, 1'b1, 11'd1607, 4'b1001);
        step_micro("brn", 3'b001, 11'd100, 32'd0, 4'b0000, 1'b0, 11'd100, 4'b1001);
        step_micro("brv", 3'b011, 11'd200, 32'd0, 4'b0000, 1'b0, 11'd101, 4'b1001);
        step_micro("brc", 3'b100, 11'd300, 32'd0, 4'b0000, 1'b0, 11'd300, 4'b1001);
        step_micro("brz_clr", 3'b010, 11'd5, 32'd0, 4'b0000, 1'b0, 11'd301, 4'b1001);

        // IR[13] branch
        step_micro("ir13_set", 3'b101, 11'd1602, 32'h0000_2000, 4'b0000, 1'b0, 11'd1602, 4'b1001);
        step_micro("jmp1600", 3'b110, 11'd1600, 32'd0, 4'b0000, 1'b0, 11'd1600, 4'b1001);
        step_micro("ir13_clr", 3'b101, 11'd1602, 32'hFFFF_DFFF, 4'b0000, 1'b0, 11'd1601, 4'b1001);

        // Wrap 2047 -> 0
        step_micro("jmp2047", 3'b110, 11'd2047, 32'd0, 4'b0000, 1'b0, 11'd2047, 4'b1001);
        step_micro("wrap", 3'b000, 11'd0, 32'd0, 4'b0000, 1'b0, 11'd0, 4'b1001);
        check_value("count before hold", 32'(micro_count), 32'd20);

        // Enable low for 5 clocks while in EXEC
        cond       = 3'b110;
        jump_addr  = 11'd500;
        flags_load = 1'b1;
        {flag_n, flag_z, flag_v, flag_c} = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_value("hold valid", 32'(micro_valid), 32'd1);
        check_value("hold csar", 32'(cs_address), 32'd0);
        check_value("hold psr", 32'(psr), 32'b1001);
        check_value("hold count", 32'(micro_count), 32'd20);
        $display("hold 5 clocks -> csar=%0d psr=%b count=%0d valid=%0d", cs_address, psr, micro_count, micro_valid);
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_value("resume csar", 32'(cs_address), 32'd500);
        check_value("resume psr", 32'(psr), 32'b0110);
        check_value("resume count", 32'(micro_count), 32'd21);
        check_value("resume valid", 32'(micro_valid), 32'd0);
        flags_load = 1'b0;

        // Asynchronous reset in the middle of an EXEC jump
        cond       = 3'b110;
        jump_addr  = 11'd1584;
        flags_load = 1'b1;
        {flag_n, flag_z, flag_v, flag_c} = 4'b1111;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_value("async csar", 32'(cs_address), 32'd0);
        check_value("async valid", 32'(micro_valid), 32'd0);
        check_value("async psr", 32'(psr), 32'd0);
        check_value("async count", 32'(micro_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_value("inreset csar", 32'(cs_address), 32'd0);
        rst = 1'b0;
        flags_load = 1'b0;
        $display("async reset -> csar=%0d psr=%b count=%0d valid=%0d", cs_address, psr, micro_count, micro_valid);
        check_value("post reset valid", 32'(micro_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_value("post reset exec valid", 32'(micro_valid), 32'd1);
        check_value("post reset csar", 32'(cs_address), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_value("post reset jump", 32'(cs_address), 32'd1584);
        check_value("post reset count", 32'(micro_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/cs_address_sequencer.md
# cs_address_sequencer

- Microsequencer that generates the 11-bit control-store address for the ARC microcode store and consumes that store's registered Condition and JumpAddress fields.
- Holds the control-store address register (CSAR) and the latched PSR flags (n, z, v, c).
- Computes the next address each microinstruction: increment, conditional or unconditional jump, or DECODE of the IR opcode fields.
- Sits directly upstream of the microcode store. Its address output drives the store's CSAddress input.

## Interface
Parameters:
- DATAWIDTH_JUMPADDRESS, 11, control-store address width
- DATAWIDTH_CONDITION, 3, microword condition field width
- DATAWIDTH_IR, 32, instruction register width
- DATAWIDTH_COUNT, 16, microinstruction counter width

Ports:
- MICROCODE_STORE_CLOCK_50  in  1  system clock, all state on rising edge
- MICROCODE_STORE_ResetInHigh_In  in  1  asynchronous, active-high reset
- SEQ_Enable_In  in  1  advance enable; low freezes all state
- SEQ_Condition_InBus  in  3  condition field of the current microword
- SEQ_JumpAddress_InBus  in  11  jump address field of the current microword
- SEQ_IR_InBus  in  32  current instruction register value
- SEQ_FlagN_In, SEQ_FlagZ_In, SEQ_FlagV_In, SEQ_FlagC_In  in  1 each  ALU result flags
- SEQ_FlagsLoad_In  in  1  current microinstruction sets condition codes
- SEQ_CSAddress_OutBus  out  11  CSAR, registered
- SEQ_MicroValid_Out  out  1  high while the store's microword is valid (EXEC state)
- SEQ_PSR_OutBus  out  4  latched flags {n,z,v,c}
- SEQ_MicroCount_OutBus  out  16  count of executed microinstructions

## Operation
FSM with two states, because the microcode store registers its output one cycle after the address:
- WAIT: CSAR is driven and the store captures its microword. Next state is EXEC.
- EXEC: the microword is valid and SEQ_MicroValid_Out=1.
  - CSAR is loaded with the next address.
  - MicroCount increments, wrapping 0xFFFF→0.
  - If SEQ_FlagsLoad_In=1, the PSR is loaded from the flag inputs.
  - Next state is WAIT.
- If SEQ_Enable_In=0, the FSM, CSAR, PSR and counter all hold.

Next-address selection in EXEC, by condition code:
- 000: CSAR+1, wrapping 2047→0.
- 001: jump if n.
- 010: jump if z.
- 011: jump if v.
- 100: jump if c.
- 101: jump if SEQ_IR_InBus[13].
- 110: unconditional jump.
- 111: DECODE, address = {1'b1, IR[31:30], IR[24:19], 2'b00}.
- "Jump" means JumpAddress. A failed condition takes CSAR+1.

Flag and IR rules:
- n, z, v, c in conditions are the registered PSR bits, i.e. the values before this EXEC's flag load.
- A branch on z in the same microword that sets flags uses the old z.
- IR[13] is sampled combinationally from SEQ_IR_InBus.

Reset (asynchronous, active-high):
- CSAR=0, state=WAIT, PSR=0000, MicroCount=0, MicroValid=0.
- Reset asserted mid-EXEC aborts the update. No partial loads are allowed.

## Timing
- Microinstruction period: 2 clocks.
- After reset release:
  - Edge 1: WAIT→EXEC, CSAR=0.
  - Edge 2: CSAR←next.
- Address-to-microword-valid latency: 1 clock.
- Condition-to-new-CSAR latency: same EXEC edge.
- All outputs come from registers. There is no combinational path from inputs to outputs.
- Enable dropping in EXEC keeps MicroValid=1 until Enable returns. The datapath must treat MicroValid&&Enable as its commit strobe.

## Test plan
- Reset, then Condition=000 for 4 microinstructions → CSAR 0,1,2,3,4. MicroValid toggles 0,1,0,1. MicroCount=4.
- Condition=111, IR=32'h8080_0000 (op=10, op3=010000) → CSAR=1600 (11'b11001000000). IR with op=00, IR[24:19]=010000 → CSAR=1088.
- Condition=010:
  - FlagZ=1, FlagsLoad=1 in a Condition=000 microword, then Z-branch to 1604 in the next microword → CSAR=1604.
  - Same flow with FlagsLoad and the branch in the same microword → CSAR=old+1.
- Condition=101, JumpAddress=1602:
  - IR[13]=1 → CSAR=1602.
  - IR[13]=0 → CSAR=1601.
- CSAR=2047, Condition=000 → CSAR=0. Enable=0 for 5 clocks in EXEC → CSAR, PSR and counter unchanged.
- Reset pulsed asynchronously mid-EXEC with Condition=110, JumpAddress=1584 → CSAR=0, state WAIT, PSR=0, jump not taken.
